// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// quotient goes to LO and remainder to HI.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic             neg_quot_q, neg_rem_q;

  logic             accept, last, div_zero;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quot_step;

  // Operand conditioning at acceptance
  assign div_zero = (divisor_i == '0);
  assign dvd_neg  = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg  = signed_i & divisor_i[WIDTH-1];
  assign dvd_abs  = dvd_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
  assign dvs_abs  = dvs_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;

  // One restoring step; the remainder is always below the divisor, so the
  // MSB of a WIDTH+1-bit difference is a reliable borrow flag.
  assign shifted   = {rem_q, quot_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign rem_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_step = {quot_q[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, stall request and completion strobe
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept  = 1'b1;
          busy_o  = 1'b1;
          state_d = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      last    = 1'b0;
    end
    if (rst_i) begin
      busy_o = 1'b0;
      done_o = 1'b0;
      accept = 1'b0;
      last   = 1'b0;
    end
  end

  // Working registers and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_o     <= '0;
      rem_o      <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= '0;
        rem_q      <= '0;
        quot_q     <= dvd_abs;
        dvsr_q     <= dvs_abs;
        neg_quot_q <= dvd_neg ^ dvs_neg;
        neg_rem_q  <= dvd_neg;
        if (div_zero) begin
          quot_o <= '1;
          rem_o  <= dividend_i;
        end
      end else if (state_q == CALC) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        rem_q  <= rem_step;
        quot_q <= quot_step;
      end
      if (last) begin
        quot_o <= neg_quot_q ? (~quot_step + WIDTH'(1)) : quot_step;
        rem_o  <= neg_rem_q ? (~rem_step + WIDTH'(1)) : rem_step;
      end
    end
  end

endmodule
